// File: rtl/mathrix_pkg.sv
// Shared definitions for the arithmetic-quiz equation checker.
package mathrix_pkg;

  // Operand and answer width; a 5-bit LFSR slice plus headroom for the sum.
  localparam int unsigned OPERAND_W = 7;

  // Fibonacci feedback taps 8,6,5,4 mapped onto bits [7:0].
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Operation codes carried on OpSub.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Checker state encoding (legacy-compatible constants).
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GEN     = 3'd1;
  localparam logic [2:0] ST_WAIT_GO = 3'd2;
  localparam logic [2:0] ST_CHECK   = 3'd3;
  localparam logic [2:0] ST_PASS    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  // One LFSR step: shift toward the MSB, feedback is the parity of the tapped bits.
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/equation_checker_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR supplying operand bits.
module lfsr8
  import mathrix_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Seed,
  output logic [7:0] Q
);

  // Load the seed on reset, otherwise advance one step every cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= Seed;
    end else begin
      Q <= lfsr_step(Q);
    end
  end

endmodule

// File: rtl/equation_checker.sv
// Presents random add/subtract equations, checks submitted answers,
// and tracks session progress and any wrong attempts.
module equation_checker
  import mathrix_pkg::*;
#(
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  parameter int unsigned NUM_EQUATIONS = 3
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Enable,
  input  logic                 Go,
  input  logic [OPERAND_W-1:0] DataIn,
  output logic [OPERAND_W-1:0] OperandA,
  output logic [OPERAND_W-1:0] OperandB,
  output logic                 OpSub,
  output logic [1:0]           EqIndex,
  output logic                 correct,
  output logic                 Wrong,
  output logic                 SessionDone
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_EQUATIONS - 1);

  logic [2:0]           state;
  logic [7:0]           lfsr;
  logic                 prev_go;
  logic                 press;
  logic [OPERAND_W-1:0] answer;
  logic [OPERAND_W-1:0] expected;
  logic [OPERAND_W-1:0] raw_a;
  logic [OPERAND_W-1:0] raw_b;
  logic [OPERAND_W-1:0] gen_a;
  logic [OPERAND_W-1:0] gen_b;
  logic [OPERAND_W-1:0] gen_res;
  logic                 gen_sub;

  lfsr8 u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .Seed  (LFSR_SEED),
    .Q     (lfsr)
  );

  assign press       = Go & ~prev_go;
  assign SessionDone = (state == ST_DONE);

  // Remember the previous Go level so a held key counts as one press.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      prev_go <= 1'b0;
    end else begin
      prev_go <= Go;
    end
  end

  // Derive the next equation from the LFSR; subtraction is ordered so the result is never negative.
  always_comb begin
    raw_a   = {2'b00, lfsr[4:0]};
    raw_b   = {2'b00, lfsr[7:3]};
    gen_sub = lfsr[0];
    gen_a   = raw_a;
    gen_b   = raw_b;
    if (gen_sub == OP_SUB && raw_b > raw_a) begin
      gen_a = raw_b;
      gen_b = raw_a;
    end
    gen_res = (gen_sub == OP_SUB) ? (gen_a - gen_b) : (gen_a + gen_b);
  end

  // Session sequencer; a low Enable aborts to IDLE ahead of any press or pending pulse.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      OperandA <= '0;
      OperandB <= '0;
      OpSub    <= 1'b0;
      EqIndex  <= '0;
      correct  <= 1'b0;
      Wrong    <= 1'b0;
      answer   <= '0;
      expected <= '0;
    end else begin
      correct <= 1'b0;
      if (!Enable) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            Wrong   <= 1'b0;
            EqIndex <= '0;
            state   <= ST_GEN;
          end
          ST_GEN: begin
            OperandA <= gen_a;
            OperandB <= gen_b;
            OpSub    <= gen_sub;
            expected <= gen_res;
            state    <= ST_WAIT_GO;
          end
          ST_WAIT_GO: begin
            if (press) begin
              answer <= DataIn;
              state  <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (answer == expected) begin
              state <= ST_PASS;
            end else begin
              Wrong <= 1'b1;
              state <= ST_WAIT_GO;
            end
          end
          ST_PASS: begin
            correct <= 1'b1;
            if (EqIndex == LAST_IDX) begin
              state <= ST_DONE;
            end else begin
              EqIndex <= EqIndex + 2'd1;
              state   <= ST_GEN;
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_equation_checker.sv
// Randomized scoreboard bench for equation_checker.
module tb_equation_checker;

  localparam logic [7:0] SEED   = 8'hA5;
  localparam int         NUM_EQ = 3;

  logic       Clock  = 1'b0;
  logic       Reset  = 1'b1;
  logic       Enable = 1'b0;
  logic       Go     = 1'b0;
  logic [6:0] DataIn = '0;
  logic [6:0] OperandA;
  logic [6:0] OperandB;
  logic       OpSub;
  logic [1:0] EqIndex;
  logic       correct;
  logic       Wrong;
  logic       SessionDone;

  equation_checker #(
    .LFSR_SEED     (SEED),
    .NUM_EQUATIONS (NUM_EQ)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Enable      (Enable),
    .Go          (Go),
    .DataIn      (DataIn),
    .OperandA    (OperandA),
    .OperandB    (OperandB),
    .OpSub       (OpSub),
    .EqIndex     (EqIndex),
    .correct     (correct),
    .Wrong       (Wrong),
    .SessionDone (SessionDone)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, new bit enters at the LSB.
  logic [7:0] m_lfsr;
  logic [7:0] lfsr_hist [int];

  // Reference session model.
  int m_a, m_b, m_res, m_idx;
  bit m_sub, m_wrong, m_done;

  typedef struct {
    int due;
    int idx;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic logic [7:0] ref_step(input logic [7:0] v);
    int   taps[4];
    logic fb;
    taps = '{8, 6, 5, 4};
    fb   = 1'b0;
    foreach (taps[i]) fb ^= v[taps[i]-1];
    return {v[6:0], fb};
  endfunction

  always @(posedge Clock) begin
    cyc    <= cyc + 1;
    m_lfsr <= Reset ? SEED : ref_step(m_lfsr);
  end

  always @(negedge Clock) lfsr_hist[cyc] = m_lfsr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every correct pulse must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (correct === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_correct", correct, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("correct_latency", cyc, mon_e.due);
        chk("correct_eqindex", EqIndex, mon_e.idx);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("correct_missing", correct, 1);
      mon_e = sb.pop_front();
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] v);
    int a, b, t;
    a     = int'(v[4:0]);
    b     = int'(v[7:3]);
    m_sub = v[0];
    if (m_sub && b > a) begin
      t = a; a = b; b = t;
    end
    m_a   = a;
    m_b   = b;
    m_res = m_sub ? a - b : a + b;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_opA"},  OperandA,    m_a);
    chk({tag, "_opB"},  OperandB,    m_b);
    chk({tag, "_sub"},  OpSub,       m_sub);
    chk({tag, "_idx"},  EqIndex,     m_idx);
    chk({tag, "_wrong"}, Wrong,      m_wrong);
    chk({tag, "_done"}, SessionDone, m_done);
  endtask

  // Raise Enable so the GEN cycle sees the target LFSR value (target < 0: immediately).
  task automatic start_session(input int target);
    int         guard;
    int         n;
    logic [7:0] v;
    guard = 0;
    if (target >= 0) begin
      v = target[7:0];
      while (ref_step(m_lfsr) != v && guard < 300) begin
        step();
        guard++;
      end
      if (guard >= 300) begin
        $display("FAIL lfsr_target: value %0d never reached", target);
        n_checks++;
      end
    end
    v      = ref_step(m_lfsr);
    Enable = 1'b1;
    n      = cyc;
    m_idx  = 0;
    m_wrong = 1'b0;
    m_done = 1'b0;
    set_ops(v);
    while (cyc < n + 2) step();
    check_state("start");
  endtask

  // Submit one answer, holding Go for 'hold' cycles.
  task automatic submit(input int ans, input int hold);
    int   n;
    bit   ok;
    exp_t e;
    n      = cyc;
    ok     = (ans == m_res);
    DataIn = 7'(ans);
    Go     = 1'b1;
    if (ok) begin
      e.due = n + 3;
      e.idx = (m_idx == NUM_EQ - 1) ? m_idx : m_idx + 1;
      sb.push_back(e);
    end
    repeat (hold) step();
    Go = 1'b0;
    while (cyc < n + 4 || cyc < n + hold + 1) step();
    if (ok) begin
      if (m_idx == NUM_EQ - 1) m_done = 1'b1;
      else begin
        m_idx++;
        set_ops(lfsr_hist[n + 3]);
      end
    end else begin
      m_wrong = 1'b1;
    end
    check_state(ok ? "after_right" : "after_wrong");
  endtask

  task automatic end_session();
    Enable = 1'b0;
    step();
    m_done = 1'b0;
    check_state("idle");
    step();
  endtask

  task automatic random_wrong(output int ans);
    ans = (m_res + int'($urandom_range(1, 62))) % 64;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int ans;
    int n;
    int guard;

    repeat (3) step();
    Reset = 1'b0;
    m_a = 0; m_b = 0; m_sub = 0; m_res = 0; m_idx = 0; m_wrong = 0; m_done = 0;
    check_state("reset");

    // Session 1: 12 + 5, long hold on equation 2, all answers right.
    start_session(8'h2C);
    submit(17, 1);
    submit(m_res, 10);
    submit(m_res, int'($urandom_range(1, 3)));
    end_session();

    // Session 2: 20 - 5 after swap; wrong then right, then abort during PASS.
    start_session(8'hA5);
    submit(14, 1);
    submit(15, 2);
    n      = cyc;
    DataIn = 7'(m_res);
    Go     = 1'b1;
    step();
    Go     = 1'b0;
    step();
    Enable = 1'b0;
    while (cyc < n + 7) step();
    check_state("abort_pass");

    // Randomized sessions with random wrong attempts and hold lengths.
    for (int s = 0; s < 4; s++) begin
      start_session(-1);
      guard = 0;
      while (!m_done && guard < 20) begin
        if ($urandom_range(0, 2) == 0) begin
          random_wrong(ans);
          submit(ans, int'($urandom_range(1, 4)));
        end else begin
          submit(m_res, int'($urandom_range(1, 4)));
        end
        guard++;
      end
      end_session();
    end

    // Enable falls in the same cycle as a Go edge.
    start_session(-1);
    random_wrong(ans);
    submit(ans, 1);
    DataIn = 7'(m_res);
    Go     = 1'b1;
    Enable = 1'b0;
    step();
    Go = 1'b0;
    check_state("drop_with_press");
    repeat (4) step();
    check_state("drop_settled");

    // Reset in WAIT_GO together with a right-answer press.
    start_session(-1);
    random_wrong(ans);
    submit(ans, 1);
    DataIn = 7'(m_res);
    Go     = 1'b1;
    Reset  = 1'b1;
    step();
    m_a = 0; m_b = 0; m_sub = 0; m_res = 0; m_idx = 0; m_wrong = 0; m_done = 0;
    check_state("mid_reset");
    Reset  = 1'b0;
    Go     = 1'b0;
    Enable = 1'b0;
    repeat (4) step();
    check_state("post_reset");

    // LFSR restarted from the seed: one more session, answered right.
    start_session(-1);
    submit(m_res, 1);
    end_session();

    repeat (4) step();
    if (sb.size() != 0) chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/equation_checker.md
EQUATION_CHECKER -- requirements
Module: equation_checker

Interface
REQ-001 SHALL have parameter LFSR_SEED, default 8'hA5, nonzero initial value of the operand LFSR.
REQ-002 SHALL have parameter NUM_EQUATIONS, default 3, the number of equations per session (range 1-3).
REQ-003 SHALL have port Clock, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port Enable, input, 1 bit: level from the top control, high while an equation state is active.
REQ-006 SHALL have port Go, input, 1 bit: answer-submit key, already debounced and active-high.
REQ-007 SHALL have port DataIn, input, 7 bits: unsigned answer from the switches.
REQ-008 SHALL have port OperandA, output, 7 bits: left operand of the current equation.
REQ-009 SHALL have port OperandB, output, 7 bits: right operand of the current equation.
REQ-010 SHALL have port OpSub, output, 1 bit: 0 means addition and 1 means subtraction.
REQ-011 SHALL have port EqIndex, output, 2 bits: zero-based index of the current equation.
REQ-012 SHALL have port correct, output, 1 bit: single-cycle pulse on a right answer.
REQ-013 SHALL have port Wrong, output, 1 bit: sticky flag, set when any wrong answer occurred in the session.
REQ-014 SHALL have port SessionDone, output, 1 bit: level, high when all equations have been answered.

Function
REQ-015 SHALL implement states IDLE, GEN, WAIT_GO, CHECK, PASS and DONE.
REQ-016 IDLE SHALL go to GEN when Enable=1; on entry to GEN it SHALL clear Wrong and set EqIndex=0.
REQ-017 GEN SHALL last one cycle and latch OperandA={2'b0,lfsr[4:0]}, OperandB={2'b0,lfsr[7:3]} and OpSub=lfsr[0], then go to WAIT_GO.
REQ-018 When OpSub=1 and B>A, GEN SHALL swap the operands so the result is never negative.
REQ-019 The expected result SHALL be registered in GEN, 7 bits wide, and cover the range 0-62 with no overflow.
REQ-020 The LFSR SHALL be 8 bits, Fibonacci, with taps 8,6,5,4, and SHALL advance every cycle while not in reset.
REQ-021 A Go press SHALL be detected as a rising edge (Go=1 and the registered previous Go=0); holding Go SHALL count as one press.
REQ-022 WAIT_GO SHALL go to CHECK on a detected press, and DataIn SHALL be captured on that same edge.
REQ-023 CHECK with a match SHALL go to PASS; with a mismatch it SHALL set Wrong and return to WAIT_GO on the same equation, with operands unchanged.
REQ-024 PASS SHALL assert correct for exactly one cycle, then increment EqIndex and go to GEN, or go to DONE if EqIndex==NUM_EQUATIONS-1.
REQ-025 Latency SHALL be: press sampled at edge k, correct high during the cycle after edge k+2.
REQ-026 DONE SHALL hold SessionDone=1 and keep Wrong, then return to IDLE when Enable=0.
REQ-027 Enable=0 in any non-IDLE state SHALL force IDLE on the next edge, holding Wrong and EqIndex, and SHALL not pulse correct.
REQ-028 Presses detected in IDLE, GEN, CHECK, PASS or DONE SHALL be ignored, with no queuing.
REQ-029 When Enable falls in the same cycle as a press is detected, Enable SHALL take priority.

Reset
REQ-030 Reset SHALL set state=IDLE, lfsr=LFSR_SEED, prevGo=0, and all outputs to 0.
REQ-031 Reset asserted mid-operation SHALL take effect on the next edge and override all other inputs.

Structure
REQ-032 Package mathrix_pkg SHALL hold the state encoding, the LFSR tap constant, the operand width (7) and the OP_ADD/OP_SUB codes.
REQ-033 The LFSR SHALL be implemented as sub-module lfsr8, with ports Clock, Reset, Seed and Q.

Verification
REQ-034 Reset, then Enable=1 -> within 2 cycles: WAIT_GO, EqIndex=0, Wrong=0, and operands consistent with lfsr8 reference model.
REQ-035 Force OperandA=12, OperandB=7, OpSub=0, apply DataIn=19 and press Go -> correct pulses one cycle, 2 cycles after the press edge, and EqIndex goes to 1.
REQ-036 With A=20, B=5, OpSub=1, apply DataIn=14 then press Go -> Wrong=1, no correct, same operands; then apply DataIn=15 and press Go -> correct pulses and Wrong stays 1.
REQ-037 Hold Go high for 10 cycles with a right answer -> exactly one correct pulse.
REQ-038 Answer 3 equations correctly -> SessionDone=1 and Wrong=0; then Enable=0 -> IDLE next cycle and SessionDone=0.
REQ-039 Drop Enable in the same cycle as a Go edge; separately, assert Reset in WAIT_GO -> IDLE, no correct pulse, and all outputs 0 after Reset.
